// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, ALU operation codes, immediate
// formats and the multicycle control state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Shared with alu.v; keep the two in step.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// Combinational instruction decode: ALU operation, operand/immediate select,
// instruction class flags and illegal-encoding detection.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_alu_ctrl,
  output logic       o_alu_src,
  output logic [1:0] o_imm_sel,
  output logic       o_mem_to_reg,
  output logic       o_reg_wr,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_branch,
  output logic       o_illegal
);

  // i_alt selects SUB over ADD and SRA over SRL.
  function automatic logic [3:0] base_op(input logic [2:0] i_f3, input logic i_alt);
    case (i_f3)
      F3_ADD:  base_op = i_alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  base_op = ALU_SLL;
      F3_SLT:  base_op = ALU_SLT;
      F3_XOR:  base_op = ALU_XOR;
      F3_SR:   base_op = i_alt ? ALU_SRA : ALU_SRL;
      F3_OR:   base_op = ALU_OR;
      F3_AND:  base_op = ALU_AND;
      default: base_op = ALU_ADD;
    endcase
  endfunction

  logic w_legal;

  always_comb begin
    o_alu_ctrl   = ALU_ADD;
    o_alu_src    = 1'b0;
    o_imm_sel    = IMM_I;
    o_mem_to_reg = 1'b0;
    o_reg_wr     = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_branch     = 1'b0;
    w_legal      = 1'b0;
    case (i_opcode)
      OP_R: begin
        o_alu_ctrl = base_op(i_funct3, i_funct7[5]);
        if (i_funct7 == F7_BASE)
          w_legal = (i_funct3 != F3_SLTU);
        else if (i_funct7 == F7_ALT)
          w_legal = (i_funct3 == F3_ADD) || (i_funct3 == F3_SR);
        o_reg_wr = w_legal;
      end
      OP_I: begin
        // instr[30] is immediate data except for shifts
        o_alu_ctrl = base_op(i_funct3, (i_funct3 == F3_SR) && i_funct7[5]);
        o_alu_src  = 1'b1;
        case (i_funct3)
          F3_SLTU: w_legal = 1'b0;
          F3_SLL:  w_legal = (i_funct7 == F7_BASE);
          F3_SR:   w_legal = (i_funct7 == F7_BASE) || (i_funct7 == F7_ALT);
          default: w_legal = 1'b1;
        endcase
        o_reg_wr = w_legal;
      end
      OP_LOAD: begin
        w_legal      = (i_funct3 == F3_WORD);
        o_alu_src    = 1'b1;
        o_mem_to_reg = w_legal;
        o_mem_rd     = w_legal;
        o_reg_wr     = w_legal;
      end
      OP_STORE: begin
        w_legal   = (i_funct3 == F3_WORD);
        o_alu_src = 1'b1;
        o_imm_sel = IMM_S;
        o_mem_wr  = w_legal;
      end
      OP_BRANCH: begin
        w_legal    = (i_funct3 == F3_BEQ);
        o_alu_ctrl = ALU_SUB;
        o_imm_sel  = IMM_B;
        o_branch   = w_legal;
      end
      default: w_legal = 1'b0;
    endcase
    o_illegal = ~w_legal;
  end

endmodule

// File: rtl/control_fsm.sv
// Five-state multicycle controller (IF/ID/EX/MEM/WB); the state register is the
// only flop and every datapath control is combinational from state and instr.
module control_fsm
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic [1:0]  ImmSel,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        loadPC,
  output logic        illegal,
  output logic [2:0]  state
);

  state_t r_state;
  state_t w_next;
  logic   w_reg_wr;
  logic   w_mem_rd;
  logic   w_mem_wr;
  logic   w_branch;
  logic   w_illegal;
  logic   w_unused;

  // Register and immediate fields belong to the datapath.
  assign w_unused = ^{instr[24:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .i_opcode     (instr[6:0]),
    .i_funct3     (instr[14:12]),
    .i_funct7     (instr[31:25]),
    .o_alu_ctrl   (ALUCtrl),
    .o_alu_src    (ALUSrc),
    .o_imm_sel    (ImmSel),
    .o_mem_to_reg (MemToReg),
    .o_reg_wr     (w_reg_wr),
    .o_mem_rd     (w_mem_rd),
    .o_mem_wr     (w_mem_wr),
    .o_branch     (w_branch),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:    w_next = S_ID;
      S_ID:    w_next = S_EX;
      S_EX:    w_next = S_MEM;
      S_MEM:   w_next = S_WB;
      default: w_next = S_IF;
    endcase
  end

  // Strobes fire only in their own state and are held low throughout reset.
  always_comb begin
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    loadPC   = 1'b0;
    PCSrc    = 1'b0;
    illegal  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_MEM: begin
          MemRead  = w_mem_rd;
          MemWrite = w_mem_wr;
        end
        S_WB: begin
          RegWrite = w_reg_wr;
          loadPC   = 1'b1;
          PCSrc    = w_branch & Zero;
          illegal  = w_illegal;
        end
        default: ;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit for the RISC-V core, sitting directly upstream of the datapath and driving every datapath control input. It decodes the current instruction word and sequences each instruction through five states (fetch, decode, execute, memory, write-back), asserting register-file, data-memory and PC-update strobes only in their designated state. Every instruction takes exactly five cycles.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- instr  in  32  current instruction word, held stable from ID through WB.
- Zero  in  1  ALU zero flag from the datapath.
- PCSrc  out  1  1 = PC + branch offset, 0 = PC + 4; meaningful only while loadPC = 1.
- ALUSrc  out  1  1 = immediate, 0 = rs2 as ALU operand 2.
- RegWrite  out  1  register-file write strobe.
- MemToReg  out  1  1 = write back memory read data, 0 = ALU result.
- ALUCtrl  out  4  ALU operation code.
- ImmSel  out  2  immediate format: 0 = I, 1 = S, 2 = B.
- MemRead  out  1  data-memory read strobe.
- MemWrite  out  1  data-memory write strobe.
- loadPC  out  1  PC update enable, one cycle per instruction.
- illegal  out  1  unsupported opcode/funct seen; pulses during WB.
- state  out  3  current FSM state, for debug and the bench.

## Operation
- States and encodings: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4.
- Transitions are unconditional: IF→ID→EX→MEM→WB→IF. Encodings 5–7 go to IF.
- Supported instructions:
  - R-type (0110011): ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA.
  - I-type (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI.
  - LW (0000011, funct3 010).
  - SW (0100011, funct3 010).
  - BEQ (1100011, funct3 000).
- ALUCtrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
- SUB vs ADD and SRA vs SRL are selected by instr[30]. For I-type, instr[30] is honoured only for shifts.
- Per-instruction decode:
  - LW and SW use ADD.
  - BEQ uses SUB with ALUSrc = 0.
  - I-type, LW and SW set ALUSrc = 1.
  - ImmSel: S for SW, B for BEQ, I otherwise.
- ALUSrc, ALUCtrl, ImmSel and MemToReg are pure combinational functions of instr, independent of state.
- Strobes:
  - MemRead = LW in MEM.
  - MemWrite = SW in MEM.
  - RegWrite = (R-type, I-type or LW) in WB.
  - MemToReg = 1 for LW only.
  - loadPC = 1 in WB for every instruction, including illegal ones.
  - PCSrc = BEQ & Zero, evaluated in WB.
- Illegal instruction: any unsupported opcode/funct3/funct7. Behaves as a NOP (no RegWrite, MemRead or MemWrite; PCSrc = 0). illegal = 1 in WB.
- Writes to x0 are not suppressed here; the register file handles x0.

## Timing
- Reset:
  - State goes to IF immediately on rst rising, with no clock needed.
  - While rst = 1: RegWrite, MemRead, MemWrite, loadPC, PCSrc and illegal are forced to 0.
  - Reset mid-instruction (e.g. in MEM) aborts it, with no write and no PC update.
  - First IF occurs on the first rising clk after rst falls.
- Latency: 5 cycles per instruction. loadPC pulses exactly once every 5 cycles.
- State register is the only flop. All outputs are combinational from state and instr, with no registered outputs.
- Zero is sampled combinationally in WB. The datapath operands are stable then because instr is held.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - ALUCtrl code constants;
  - ImmSel constants;
  - the state enum.
- The ALU code is shared with alu.v.
- One sub-module, `alu_decoder`: combinational opcode/funct3/funct7 → ALUCtrl, ALUSrc, ImmSel, illegal-decode. The FSM and strobe gating live in control_fsm.

## Test plan
- Reset mid-MEM with SW loaded → state = 0 immediately; MemWrite, loadPC = 0; after release, state steps 0,1,2,3,4.
- ADD x3,x1,x2 (0x002081B3) → ALUCtrl = 0010, ALUSrc = 0; RegWrite = 1 only in WB; loadPC = 1 only in WB; PCSrc = 0.
- LW x5,8(x0) (0x00802283) → MemRead = 1 only in MEM; MemToReg = 1; ALUSrc = 1; RegWrite in WB. SW x5,12(x0) (0x00502623) → MemWrite = 1 only in MEM; ImmSel = 1; RegWrite never asserted.
- BEQ x0,x0,+8 (0x00000463): with Zero = 1 → PCSrc = 1 with loadPC in WB, ALUCtrl = 0110, ImmSel = 2. With Zero = 0 → PCSrc = 0.
- SRAI x1,x1,3 (0x4030D093) → ALUCtrl = 1010. ADDI with instr[30] = 1 → ALUCtrl = 0010.
- Illegal 0xFFFFFFFF → no RegWrite, MemRead or MemWrite; illegal = 1 and loadPC = 1 in WB; PCSrc = 0.
